exe_stage: RTL
==============

// Module: exe_stage
// PURPOSE
//  Execute stage of the 16-bit pipeline, directly downstream of the ID/EXE register and feeding the EXE/MEM register.
//  - Single-cycle ALU ops: combinational, zero added latency.
//  - MUL/DIV/REM: run on an iterative shift-add / restoring unit; exo_stall freezes ID/EXE and upstream while busy.
//  - Passes pc, instr, wreg_addr, rwe and store data through to EXE/MEM; emits a bubble while stalled.
// PARAMETERS
//  DATA_W  16  datapath width; MUL/DIV iteration count = DATA_W
//  OP_W     8  ALU opcode width
//  REG_W    4  register address width
// PORTS
//  iei_clk               in   1       clock, rising edge
//  iei_rst               in   1       asynchronous reset, active-low
//  exi_flush             in   1       synchronous flush; aborts any mul/div in progress
//  exi_instr, exi_pc     in   16      passthrough from ID/EXE
//  exi_alu_opcode        in   OP_W    ALU_* code from defines.v
//  exi_op1, exi_op2      in   DATA_W  operands (op2[3:0] = shift amount)
//  exi_wreg_addr         in   REG_W   destination register; REG_INVALID = none
//  exi_rwe               in   2       memory read/write enable
//  exi_write_to_mem_data in   DATA_W  store data
//  exo_result            out  DATA_W  ALU / mul / div result; also the memory address
//  exo_instr, exo_pc     out  16      passthrough
//  exo_wreg_addr         out  REG_W   destination; REG_INVALID while stalled
//  exo_rwe               out  2       0 while stalled
//  exo_write_to_mem_data out  DATA_W  passthrough
//  exo_stall             out  1       hold ID/EXE (drives its enable low) and all upstream stages
//  exo_busy              out  1       mul/div FSM is in BUSY
// BEHAVIOUR
//  Reset (iei_rst=0, async):
//   - FSM goes to IDLE; count, acc, quot and rem registers cleared.
//   - All outputs are zero except exo_wreg_addr = REG_INVALID (stall, busy, rwe, result all 0).
//  ALU ops (combinational), result width DATA_W with carry discarded:
//   - ADD, SUB, AND, OR, XOR, NOT(op1), MOV(op1)
//   - SLL, SRL, SRA by op2[3:0]
//   - SLT (signed) and SLTU: result 1 or 0
//   - CMP: 0 if op1==op2, else 1
//   - NOP or undefined opcode: result 0, wreg/rwe passed through unchanged
//  MUL/DIV/REM FSM, states IDLE -> BUSY -> DONE -> IDLE:
//   - IDLE with a MUL/DIV/REM opcode and no flush (issue cycle): stall=1, bubble out; operands latched at the edge; -> BUSY, count=0.
//   - BUSY: one iteration per cycle; stall=1, busy=1, bubble out; -> DONE when count==DATA_W-1, i.e. DATA_W cycles.
//   - DONE: stall=0; result driven from the unit; wreg/rwe pass through; -> IDLE at the next edge while ID/EXE loads the next instr.
//   - Total: DATA_W+1 stall cycles; result visible in cycle DATA_W+2 counted from issue.
//   - MUL: unsigned, low DATA_W bits of the product.
//   - DIV/REM: unsigned restoring division.
//   - Divide by zero: quotient 16'hFFFF, remainder = op1; full latency, no early exit.
//  Boundaries:
//   - Flush in IDLE, BUSY or DONE: -> IDLE at the next edge; stall drops that edge; no result emitted.
//   - Flush in the same cycle as issue: flush wins, no start.
//   - Back-to-back mul/div: DONE -> IDLE -> new issue; no zero-stall fast path.
//   - Reset mid-operation aborts immediately; outputs take reset values asynchronously.
//   - Bubble = wreg_addr REG_INVALID, rwe 0, result 0; pc and instr still pass through.
// STRUCTURE
//  - defines.v (shared): ALU_* opcode constants incl. ALU_MUL/ALU_DIV/ALU_REM, REG_INVALID, RWE_* encodings, MD_* state codes.
//  - One sub-module, muldiv_seq:
//    - inputs: start, op select, a, b, flush
//    - outputs: busy, done, result; owns the IDLE/BUSY/DONE FSM and count.
//  - exe_stage: comb ALU, bubble/stall muxing, passthroughs.
// TESTING
//  1. ADD 0x7FFF+0x0001, wreg=3 -> result 0x8000, wreg 3, stall 0, same cycle.
//  2. MUL 0x0012*0x0034 -> stall high 17 cycles, bubbles out, then result 0x03A8 one cycle, stall 0.
//  3. DIV 100,7 -> 14; REM 100,7 -> 2; each 17 stall cycles.
//  4. DIV 0x1234,0 -> result 0xFFFF; REM 0x1234,0 -> 0x1234; full latency.
//  5. MUL issued, flush at BUSY cycle 5 -> IDLE next edge, stall 0, no result; next ADD 2+2 -> 4.
//  6. Reset low at BUSY cycle 8 -> stall/busy 0, wreg REG_INVALID at once; after release, MUL 3*5 -> 15.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: opcode, register and mul/div encodings shared by the execute stage.
package exe_stage_pkg;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_AND  = 8'h03;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_XOR  = 8'h05;
  localparam logic [7:0] ALU_NOT  = 8'h06;
  localparam logic [7:0] ALU_MOV  = 8'h07;
  localparam logic [7:0] ALU_SLL  = 8'h08;
  localparam logic [7:0] ALU_SRL  = 8'h09;
  localparam logic [7:0] ALU_SRA  = 8'h0A;
  localparam logic [7:0] ALU_SLT  = 8'h0B;
  localparam logic [7:0] ALU_SLTU = 8'h0C;
  localparam logic [7:0] ALU_CMP  = 8'h0D;
  localparam logic [7:0] ALU_MUL  = 8'h0E;
  localparam logic [7:0] ALU_DIV  = 8'h0F;
  localparam logic [7:0] ALU_REM  = 8'h10;
  localparam logic [3:0] REG_INVALID = 4'hF;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_op_t;
  function automatic logic is_muldiv(input logic [7:0] op);
    return op inside {ALU_MUL, ALU_DIV, ALU_REM};
  endfunction
endpackage

// File: rtl/exe_stage_muldiv_seq.sv
// exe_stage_muldiv_seq: iterative shift-add multiplier / restoring divider, one bit per cycle.
module exe_stage_muldiv_seq
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              iei_clk,
  input  logic              iei_rst,
  input  logic              start,
  input  md_op_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int CW = $clog2(DATA_W);
  md_state_t state, state_nx;
  md_op_t op_q;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] acc, quot, rem, dvs, diff;
  logic [DATA_W:0] rsh;
  logic ge;
  always_comb begin
    state_nx = flush ? MD_IDLE
             : (state == MD_IDLE && start) ? MD_BUSY
             : (state == MD_BUSY && count == CW'(DATA_W - 1)) ? MD_DONE
             : (state == MD_DONE) ? MD_IDLE : state;
  end
  // For MUL, quot holds the shifting multiplier and rem the shifting multiplicand.
  assign rsh  = {rem, quot[DATA_W-1]};
  assign ge   = rsh >= {1'b0, dvs};
  assign diff = rsh[DATA_W-1:0] - dvs;
  always_ff @(posedge iei_clk or negedge iei_rst) begin
    if (!iei_rst) begin
      state <= MD_IDLE;
      op_q  <= MD_MUL;
      count <= '0;
      acc   <= '0;
      quot  <= '0;
      rem   <= '0;
      dvs   <= '0;
    end else begin
      state <= state_nx;
      if (state == MD_IDLE && start && !flush) begin
        op_q  <= op;
        count <= '0;
        acc   <= '0;
        quot  <= op == MD_MUL ? b : a;
        rem   <= op == MD_MUL ? a : '0;
        dvs   <= b;
      end else if (state == MD_BUSY) begin
        count <= count + CW'(1);
        if (op_q == MD_MUL) begin
          acc  <= acc + (quot[0] ? rem : '0);
          quot <= quot >> 1;
          rem  <= rem << 1;
        end else begin
          rem  <= ge ? diff : rsh[DATA_W-1:0];
          quot <= {quot[DATA_W-2:0], ge};
        end
      end
    end
  end
  assign busy   = state == MD_BUSY;
  assign done   = state == MD_DONE;
  assign result = op_q == MD_MUL ? acc : op_q == MD_DIV ? quot : rem;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: combinational ALU plus sequential mul/div with stall and bubble generation.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8,
  parameter int REG_W  = 4
) (
  input  logic              iei_clk,
  input  logic              iei_rst,
  input  logic              exi_flush,
  input  logic [15:0]       exi_instr,
  input  logic [15:0]       exi_pc,
  input  logic [OP_W-1:0]   exi_alu_opcode,
  input  logic [DATA_W-1:0] exi_op1,
  input  logic [DATA_W-1:0] exi_op2,
  input  logic [REG_W-1:0]  exi_wreg_addr,
  input  logic [1:0]        exi_rwe,
  input  logic [DATA_W-1:0] exi_write_to_mem_data,
  output logic [DATA_W-1:0] exo_result,
  output logic [15:0]       exo_instr,
  output logic [15:0]       exo_pc,
  output logic [REG_W-1:0]  exo_wreg_addr,
  output logic [1:0]        exo_rwe,
  output logic [DATA_W-1:0] exo_write_to_mem_data,
  output logic              exo_stall,
  output logic              exo_busy
);
  logic is_md, md_busy, md_done, bubble;
  logic [DATA_W-1:0] alu, md_result;
  md_op_t md_op;
  assign is_md = is_muldiv(exi_alu_opcode);
  assign md_op = exi_alu_opcode == ALU_MUL ? MD_MUL : exi_alu_opcode == ALU_DIV ? MD_DIV : MD_REM;
  exe_stage_muldiv_seq #(.DATA_W(DATA_W)) u_md (
    .iei_clk (iei_clk),
    .iei_rst (iei_rst),
    .start   (is_md && !exi_flush),
    .op      (md_op),
    .a       (exi_op1),
    .b       (exi_op2),
    .flush   (exi_flush),
    .busy    (md_busy),
    .done    (md_done),
    .result  (md_result)
  );
  always_comb begin
    case (exi_alu_opcode)
      ALU_ADD:  alu = exi_op1 + exi_op2;
      ALU_SUB:  alu = exi_op1 - exi_op2;
      ALU_AND:  alu = exi_op1 & exi_op2;
      ALU_OR:   alu = exi_op1 | exi_op2;
      ALU_XOR:  alu = exi_op1 ^ exi_op2;
      ALU_NOT:  alu = ~exi_op1;
      ALU_MOV:  alu = exi_op1;
      ALU_SLL:  alu = exi_op1 << exi_op2[3:0];
      ALU_SRL:  alu = exi_op1 >> exi_op2[3:0];
      ALU_SRA:  alu = $unsigned($signed(exi_op1) >>> exi_op2[3:0]);
      ALU_SLT:  alu = DATA_W'($signed(exi_op1) < $signed(exi_op2));
      ALU_SLTU: alu = DATA_W'(exi_op1 < exi_op2);
      ALU_CMP:  alu = DATA_W'(exi_op1 != exi_op2);
      default:  alu = '0;
    endcase
  end
  // Issue cycle stalls too; a flushed mul/div never starts and never emits.
  assign exo_stall = iei_rst && (md_busy || (!md_busy && !md_done && is_md && !exi_flush));
  assign exo_busy  = md_busy;
  assign bubble    = !iei_rst || exo_stall || (exi_flush && is_md);
  assign exo_result            = bubble ? '0 : md_done ? md_result : alu;
  assign exo_wreg_addr         = bubble ? REG_W'(REG_INVALID) : exi_wreg_addr;
  assign exo_rwe               = bubble ? 2'b00 : exi_rwe;
  assign exo_pc                = iei_rst ? exi_pc : '0;
  assign exo_instr             = iei_rst ? exi_instr : '0;
  assign exo_write_to_mem_data = iei_rst ? exi_write_to_mem_data : '0;
endmodule
